// File: rtl/pn_pkg.sv
// Shared encodings and default sizes for the Polish-Notation token transmitter.
package pn_pkg;

    localparam logic [1:0] MODE_PRE_DESC = 2'd0;
    localparam logic [1:0] MODE_POST_ASC = 2'd1;
    localparam logic [1:0] MODE_PREFIX   = 2'd2;
    localparam logic [1:0] MODE_POSTFIX  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_ABS = 3'd3;

    localparam int PN_MAX_TOK   = 12;
    localparam int PN_RES_DEPTH = 4;
    localparam int PN_TIMEOUT   = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_CAPT,
        ST_DONE
    } state_t;

    // Prefix/postfix evaluate a single expression; the other modes yield one result per 3 tokens.
    function automatic logic [7:0] expected_results(input logic [1:0] mode, input int unsigned tokens);
        if (mode == MODE_PREFIX || mode == MODE_POSTFIX) begin
            return 8'd1;
        end
        return 8'(tokens / 3);
    endfunction

endpackage

// File: rtl/pn_res_fifo.sv
// Result FIFO: synchronous, first-word-fall-through head, pop-then-push when full,
// head holds its last value while empty.
module pn_res_fifo
    import pn_pkg::*;
#(
    parameter int DEPTH = PN_RES_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [NW-1:0]    count;
    logic [WIDTH-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == NW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? hold : mem[rd_ptr];

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            hold <= head;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= bump(wr_ptr);
                end
                if (do_pop) begin
                    rd_ptr <= bump(rd_ptr);
                end
                if (do_push && !do_pop) begin
                    count <= count + 1'b1;
                end else if (do_pop && !do_push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pn_token_tx.sv
// Transmit side of the PN token interface: replays buffered tokens as a burst and collects results.
// Optional expected-count check enabled by defining PN_TX_CHECK_EN.
module pn_token_tx
    import pn_pkg::*;
#(
    parameter int MAX_TOK   = PN_MAX_TOK,
    parameter int RES_DEPTH = PN_RES_DEPTH,
    parameter int TIMEOUT   = PN_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tok_wr,
    input  logic               tok_op,
    input  logic [2:0]         tok_val,
    output logic               tok_full,
    input  logic               start,
    input  logic [1:0]         start_mode,
    output logic               busy,
    output logic [1:0]         pn_mode,
    output logic               pn_operator,
    output logic [2:0]         pn_in,
    output logic               pn_in_valid,
    input  logic               pn_out_valid,
    input  logic signed [31:0] pn_out,
    output logic               res_valid,
    output logic signed [31:0] res_data,
    input  logic               res_ready,
    output logic               done,
    output logic               err_timeout,
    output logic               err_ovf,
    output logic               err_count
);

    localparam int CW = $clog2(MAX_TOK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [3:0]    tok_buf [MAX_TOK];
    logic [CW-1:0] tok_cnt;
    logic [CW-1:0] rd_idx;
    logic [TW-1:0] wait_cnt;
    logic          tok_accept;
    logic          start_accept;
    logic          res_push;
    logic          res_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_hit;
    logic          wait_expired;
    logic          enter_done;

    assign tok_full     = (tok_cnt == CW'(MAX_TOK));
    assign busy         = (state != ST_IDLE);
    assign start_accept = (state == ST_IDLE) && start && (tok_cnt != '0);
    assign tok_accept   = (state == ST_IDLE) && tok_wr && !tok_full && !start_accept;
    assign res_push     = pn_out_valid && ((state == ST_WAIT) || (state == ST_CAPT));
    assign res_valid    = !fifo_empty;
    assign res_pop      = res_ready && res_valid;
    assign ovf_hit      = res_push && fifo_full && !res_pop;
    assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
    assign enter_done   = !pn_out_valid &&
                          ((state == ST_CAPT) || ((state == ST_WAIT) && wait_expired));

    always_ff @(posedge clk) begin
        if (tok_accept) begin
            tok_buf[tok_cnt] <= {tok_op, tok_val};
        end
    end

    pn_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (32)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_accept),
        .push      (res_push && !ovf_hit),
        .push_data (pn_out),
        .pop       (res_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (res_data)
    );

    // Token outputs are registered and forced to zero outside the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tok_cnt     <= '0;
            rd_idx      <= '0;
            wait_cnt    <= '0;
            pn_mode     <= 2'd0;
            pn_operator <= 1'b0;
            pn_in       <= 3'd0;
            pn_in_valid <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enter_done) begin
                done    <= 1'b1;
                tok_cnt <= '0;
            end else if (tok_accept) begin
                tok_cnt <= tok_cnt + 1'b1;
            end
            if (ovf_hit) begin
                err_ovf <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        state                <= ST_SEND;
                        err_timeout          <= 1'b0;
                        err_ovf              <= 1'b0;
                        pn_in_valid          <= 1'b1;
                        pn_mode              <= start_mode;
                        {pn_operator, pn_in} <= tok_buf[0];
                        rd_idx               <= CW'(1);
                    end
                end
                ST_SEND: begin
                    if (rd_idx < tok_cnt) begin
                        {pn_operator, pn_in} <= tok_buf[rd_idx];
                        rd_idx               <= rd_idx + 1'b1;
                    end else begin
                        state       <= ST_WAIT;
                        wait_cnt    <= '0;
                        pn_in_valid <= 1'b0;
                        pn_mode     <= 2'd0;
                        pn_operator <= 1'b0;
                        pn_in       <= 3'd0;
                    end
                end
                ST_WAIT: begin
                    if (pn_out_valid) begin
                        state <= ST_CAPT;
                    end else if (wait_expired) begin
                        state       <= ST_DONE;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CAPT: begin
                    if (!pn_out_valid) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PN_TX_CHECK_EN
    logic [7:0] cap_cnt;
    logic [7:0] exp_cnt;

    // Dropped pushes still count as results seen; the counter saturates on runaway bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt   <= 8'd0;
            exp_cnt   <= 8'd0;
            err_count <= 1'b0;
        end else if (start_accept) begin
            cap_cnt   <= 8'd0;
            exp_cnt   <= expected_results(start_mode, 32'(tok_cnt));
            err_count <= 1'b0;
        end else begin
            if (res_push && (cap_cnt != 8'hFF)) begin
                cap_cnt <= cap_cnt + 1'b1;
            end
            if (enter_done && (cap_cnt != exp_cnt)) begin
                err_count <= 1'b1;
            end
        end
    end
`else
    assign err_count = 1'b0;
`endif

endmodule
